// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two-requester round-robin front end sharing one registered add/sub unit
module addsub_arbiter #(
    parameter int nbit = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [nbit-1:0] req0_a,
    input  logic [nbit-1:0] req0_b,
    input  logic            req0_sub,
    input  logic [nbit-1:0] req1_a,
    input  logic [nbit-1:0] req1_b,
    input  logic            req1_sub,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [nbit-1:0] rsp_data,
    output logic            rsp_cout
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            ptr_q, ptr_d;
    logic [nbit-1:0] data_q, data_d;
    logic            cout_q, cout_d;
    logic            drain, accept_en;
    logic [1:0]      gnt;
    logic [nbit-1:0] op_a, op_b;
    logic            op_sub;
    logic [nbit:0]   sum;
    always_comb begin
        drain     = state_q == FULL && rsp_ready[owner_q];
        accept_en = state_q == EMPTY || drain;
        gnt       = !accept_en ? 2'b00 : req_valid == 2'b11 ? (ptr_q ? 2'b10 : 2'b01) : req_valid;
        op_a      = gnt[1] ? req1_a : req0_a;
        op_b      = gnt[1] ? req1_b : req0_b;
        op_sub    = gnt[1] ? req1_sub : req0_sub;
        sum       = {1'b0, op_a} + {1'b0, op_sub ? ~op_b : op_b} + {{nbit{1'b0}}, op_sub};
        state_d   = gnt != 2'b00 ? FULL : drain ? EMPTY : state_q;
        owner_d   = gnt != 2'b00 ? gnt[1] : owner_q;
        ptr_d     = gnt != 2'b00 ? ~gnt[1] : ptr_q;
        data_d    = gnt != 2'b00 ? sum[nbit-1:0] : data_q;
        cout_d    = gnt != 2'b00 ? sum[nbit] : cout_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            data_q  <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            cout_q  <= cout_d;
        end
    end
    assign req_ready = rst_n ? gnt : 2'b00;
    assign rsp_valid = state_q == FULL ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = data_q;
    assign rsp_cout  = cout_q;
endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: nbit, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: requester i's operation is accepted this cycle.
REQ-006 req0_a, req0_b  input  nbit each  requester 0 operands.
REQ-007 req0_sub  input  1  requester 0 op select: 0 = a+b, 1 = a-b.
REQ-008 req1_a, req1_b, req1_sub  input  nbit, nbit, 1  requester 1 operands and op select.
REQ-009 rsp_valid  output  2  bit i: result register holds requester i's result (one-hot or zero).
REQ-010 rsp_ready  input  2  bit i: requester i consumes its result this cycle.
REQ-011 rsp_data  output  nbit  registered result.
REQ-012 rsp_cout  output  1  registered carry-out of the nbit-bit addition.

Function
REQ-013 The block SHALL share one nbit add/sub datapath between two requesters through a single-entry result register.
REQ-014 Arithmetic: add = a + b; sub = a + ~b + 1; rsp_data = low nbit bits; rsp_cout = carry out of bit nbit-1 (sub: 1 = no borrow, 0 = borrow).
REQ-015 States: EMPTY (rsp_valid = 00), FULL (rsp_valid one-hot).
REQ-016 Drain: in FULL, a handshake occurs when rsp_ready bit matching the valid rsp_valid bit is 1; rsp_ready bits of the other requester are ignored.
REQ-017 Accept-enable: acceptance is permitted when state is EMPTY or a drain occurs in the same cycle (throughput one operation per cycle).
REQ-018 Grant: when accept is permitted, exactly one req_ready bit is 1, chosen among asserted req_valid bits; otherwise req_ready = 00.
REQ-019 Round-robin: a 1-bit priority pointer names the preferred requester; if both valid, the preferred one is granted; if only one is valid, it is granted regardless of pointer.
REQ-020 After any grant, the pointer SHALL be set to the non-granted requester; no grant leaves it unchanged.
REQ-021 req_ready SHALL be combinational from req_valid, pointer, state and rsp_ready; it SHALL NOT depend on operand or op-select inputs.
REQ-022 Latency: operation accepted in cycle N appears with rsp_valid, rsp_data, rsp_cout at the start of cycle N+1.
REQ-023 Drain without accept: next state EMPTY, rsp_valid = 00; rsp_data/rsp_cout hold last values.
REQ-024 While FULL and not drained, rsp_valid, rsp_data, rsp_cout SHALL remain stable and req_ready = 00.
REQ-025 Operands are sampled only on the accept cycle; later changes do not affect the held result.

Reset
REQ-026 While rst_n = 0, rsp_valid = 00, rsp_data = 0, rsp_cout = 0, pointer = 0 (requester 0 preferred), state EMPTY, asynchronously.
REQ-027 req_ready SHALL be 00 while rst_n = 0.
REQ-028 Reset asserted mid-operation SHALL discard the held result; first cycle after release behaves as EMPTY with pointer 0.

Verification (nbit = 32)
REQ-029 Reset, req_valid=01, req0 5+3 add -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_data=8, rsp_cout=0.
REQ-030 req_valid=11 held, rsp_ready=11 -> grants 01,10,01,10 on consecutive cycles; rsp_valid alternates 01,10 one cycle later.
REQ-031 req0 sub 3-5 -> rsp_data=0xFFFFFFFE, rsp_cout=0; req1 sub 5-3 -> rsp_data=2, rsp_cout=1.
REQ-032 req0 add 0xFFFFFFFF+1 -> rsp_data=0, rsp_cout=1; rsp_ready=00 for 3 cycles -> outputs stable, req_ready=00; rsp_ready=01 -> drained, new accept same cycle.
REQ-033 FULL with rsp_valid=10, rsp_ready=01 -> no drain, state unchanged.
REQ-034 FULL, rst_n pulsed low mid-cycle -> rsp_valid=00 immediately; after release, req_valid=11 -> requester 0 granted first.
